// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures clk cycles between rising edges of an asynchronous pulse stream.
module pulse_period_meter #(
  parameter int WIDTH     = 8,
  parameter int MIN_EDGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] period,
  output logic             meas_valid,
  output logic             overflow,
  output logic             overrun,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  // ARM needs at least one edge so the first period starts on a real edge
  localparam int unsigned ARM_LAST = (MIN_EDGES > 1) ? MIN_EDGES - 1 : 1;
  state_t state_q, state_d;
  logic meta_q, sync_q, prev_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic sat_q, sat_d, valid_q, valid_d, ovf_q, ovf_d, overrun_q, overrun_d;
  logic rise, result, load;
  assign rise = sync_q & ~prev_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    result  = 1'b0;
    case (state_q)
      IDLE: state_d = ARM;
      ARM: if (rise) begin
        if (32'(cnt_q) + 32'd1 >= 32'(ARM_LAST)) begin
          state_d = MEASURE;
          cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: if (rise) begin
        result = 1'b1;
        cnt_d  = {{(WIDTH-1){1'b0}}, 1'b1};
        sat_d  = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    load      = result & (~valid_q | meas_ready);
    valid_d   = load | (valid_q & ~meas_ready);
    period_d  = load ? (sat_q ? CNT_MAX : cnt_q) : period_q;
    ovf_d     = load ? sat_q : ovf_q;
    overrun_d = overrun_q | (result & valid_q & ~meas_ready);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= pulse_in;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end
  assign period     = period_q;
  assign meas_valid = valid_q;
  assign overflow   = ovf_q;
  assign overrun    = overrun_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed checks of period measurement, saturation, backpressure and reset.
module tb_pulse_period_meter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pulse_in = 1'b0;
  logic meas_ready = 1'b0;
  logic [7:0] period;
  logic meas_valid, overflow, overrun, busy;
  int n_checks = 0;
  int n_pass = 0;
  logic exp_v;

  pulse_period_meter #(.WIDTH(8), .MIN_EDGES(2)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .meas_ready(meas_ready),
    .period(period), .meas_valid(meas_valid), .overflow(overflow),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // drive pulse_in for one cycle; outputs are sampled 1ns after the edge
  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pulse_in = 1'b0;
    meas_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_period", period, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    step(1'b0);
    check("busy_after_release", busy, 1);

    // period 5 with ready held high
    do_reset();
    meas_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      step(c % 5 == 0);
      exp_v = (c >= 7) && ((c - 7) % 5 == 0);
      check("p5_valid", meas_valid, exp_v);
      if (exp_v) begin
        check("p5_period", period, 5);
        check("p5_overflow", overflow, 0);
      end
    end

    // saturation then a normal 10-cycle gap
    do_reset();
    meas_ready = 1'b1;
    for (int c = 0; c < 314; c++) begin
      step(c == 0 || c == 301 || c == 311);
      if (c == 302) check("sat_not_yet", meas_valid, 0);
      if (c == 303) begin
        check("sat_valid", meas_valid, 1);
        check("sat_period", period, 255);
        check("sat_overflow", overflow, 1);
      end
      if (c == 313) begin
        check("post_sat_valid", meas_valid, 1);
        check("post_sat_period", period, 10);
        check("post_sat_overflow", overflow, 0);
      end
    end

    // backpressure: period 6, three edges, ready low
    do_reset();
    for (int c = 0; c < 16; c++) begin
      meas_ready = (c == 15);
      step(c % 6 == 0 && c <= 12);
      if (c == 8) begin
        check("bp_first_valid", meas_valid, 1);
        check("bp_first_period", period, 6);
      end
      if (c == 13) check("bp_overrun_before", overrun, 0);
      if (c == 14) begin
        check("bp_hold_valid", meas_valid, 1);
        check("bp_hold_period", period, 6);
        check("bp_overrun", overrun, 1);
      end
      if (c == 15) check("bp_accept_clears", meas_valid, 0);
    end
    meas_ready = 1'b0;
    step(1'b0);
    check("bp_overrun_sticky", overrun, 1);

    // accept coincides with a new result
    do_reset();
    for (int c = 0; c < 16; c++) begin
      meas_ready = (c == 15);
      step(c == 0 || c == 6 || c == 13);
      if (c == 14) check("sim_period_before", period, 6);
      if (c == 15) begin
        check("sim_valid", meas_valid, 1);
        check("sim_period", period, 7);
        check("sim_overrun", overrun, 0);
      end
    end
    meas_ready = 1'b0;

    // reset in the middle of a period-9 measurement with a result pending
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(c == 0 || c == 9);
      if (c == 11) begin
        check("mid_valid", meas_valid, 1);
        check("mid_period", period, 9);
      end
    end
    reset = 1'b0;
    #1;
    check("mid_rst_period", period, 0);
    check("mid_rst_valid", meas_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0);
    meas_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(c == 0 || c == 9);
      if (c < 11) check("rearm_no_result", meas_valid, 0);
      else begin
        check("rearm_valid", meas_valid, 1);
        check("rearm_period", period, 9);
      end
    end

    // fastest input: pulse_in toggling every cycle
    do_reset();
    meas_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(c % 2 == 0);
      exp_v = (c >= 4) && (c % 2 == 0);
      check("min_valid", meas_valid, exp_v);
      if (exp_v) begin
        check("min_period", period, 2);
        check("min_overflow", overflow, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the period counter and result width.
REQ-002 The block SHALL have parameter MIN_EDGES, default 2, setting the rising edges required before the first result.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port pulse_in, input, 1 bit: asynchronous pulse stream, e.g. a divider output.
REQ-006 The block SHALL have port meas_ready, input, 1 bit: the consumer accepts the result.
REQ-007 The block SHALL have port period, output, WIDTH bits: measured clk cycles between consecutive rising edges.
REQ-008 The block SHALL have port meas_valid, output, 1 bit: period holds an unconsumed result.
REQ-009 The block SHALL have port overflow, output, 1 bit: the current result saturated.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag; at least one result was dropped.
REQ-011 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-012 pulse_in SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; a rising edge is sync_q=1 and prev_q=0.
REQ-013 Edge latency SHALL be fixed: detected edge is 3 clk cycles after pulse_in is first sampled high.
REQ-014 The FSM SHALL have states IDLE, ARM and MEASURE.
REQ-015 IDLE SHALL go to ARM unconditionally one cycle after reset release.
REQ-016 ARM SHALL count detected edges; when the count reaches MIN_EDGES-1, it SHALL clear cnt to 1 and enter MEASURE.
REQ-017 In MEASURE, cnt SHALL increment by 1 per cycle with no detected edge, saturating at 2^WIDTH-1.
REQ-018 When cnt saturates, the block SHALL set an internal sat flag.
REQ-019 On a detected edge in MEASURE, the block SHALL produce a result: period = cnt (or all-ones if sat), and overflow = sat.
REQ-020 On each result, cnt SHALL reload to 1 and sat SHALL clear in the same cycle.
REQ-021 A result SHALL load period/overflow and set meas_valid on the following clk edge if meas_valid=0, or if meas_valid=1 and meas_ready=1 in that cycle.
REQ-022 If meas_valid=1 and meas_ready=0 when a result is produced, the new result SHALL be dropped, period SHALL hold, and overrun SHALL set.
REQ-023 If meas_valid=1, meas_ready=1 and no result is produced, meas_valid SHALL clear next cycle.
REQ-024 period and overflow SHALL stay stable while meas_valid=1 and meas_ready=0.
REQ-025 meas_ready SHALL be ignored while meas_valid=0.
REQ-026 overrun SHALL clear only on reset.
REQ-027 busy SHALL be 1 in ARM and MEASURE.
REQ-028 Period 1 SHALL be unreachable because of edge-detector spacing; the minimum reported period SHALL be 2.

Reset
REQ-029 While reset=0, all state SHALL clear asynchronously: FSM=IDLE; sync/edge flops=0; cnt=0; sat=0.
REQ-030 While reset=0, all outputs SHALL be 0: period=0, meas_valid=0, overflow=0, overrun=0, busy=0.
REQ-031 reset asserted mid-measurement SHALL discard partial counts and any pending result.
REQ-032 After reset release, the first result SHALL again require MIN_EDGES edges.
REQ-033 Release of reset SHALL take effect on the next rising clk edge.

Verification
REQ-034 Periodic pulse: pulse_in high 1 cycle every 5, meas_ready=1 -> first meas_valid 3 cycles after the 2nd pulse, period=5, overflow=0; repeats every 5 cycles.
REQ-035 Saturation (WIDTH=8): a pulse, then 300 quiet cycles, then a pulse -> period=255, overflow=1; the next 10-cycle gap gives period=10, overflow=0.
REQ-036 Backpressure: meas_ready=0, period 6, 3 edges -> first result period=6 held; 2nd result dropped; overrun=1.
REQ-036a Backpressure, continued: then meas_ready=1 for 1 cycle -> meas_valid=0 next cycle unless an edge coincides.
REQ-037 Simultaneous accept and new result -> meas_valid stays 1, period updates to the new value, overrun unchanged.
REQ-038 Reset mid-count: 4 cycles into a period-9 measurement assert reset=0 -> all outputs 0 immediately.
REQ-038a Reset mid-count, continued: after release, the 1st edge gives no result and the 2nd edge gives the correct period.
REQ-039 Minimum period: pulse_in toggling every cycle -> period=2 every 2 cycles, overflow=0.
